// File: rtl/us_multich_detect_ctrl_if.sv
// Burst-generator handshake and per-channel detect/report signals for us_multich_detect_ctrl.
interface us_multich_detect_ctrl_if #(
  parameter int NCH   = 2,
  parameter int CNT_W = 20
);
  localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;

  logic             tuss_ready;
  logic             burst_finish;
  logic [NCH-1:0]   echo_in;
  logic             fault_clr;
  logic             burst_en;
  logic             burst_rstn;
  logic [CH_W-1:0]  ch_sel;
  logic [NCH-1:0]   detected;
  logic [CNT_W-1:0] tof;
  logic [CH_W-1:0]  tof_ch;
  logic             tof_valid;
  logic             burst_fault;

  modport master (
    output tuss_ready, burst_finish, echo_in, fault_clr,
    input  burst_en, burst_rstn, ch_sel, detected, tof, tof_ch, tof_valid, burst_fault
  );

  modport slave (
    input  tuss_ready, burst_finish, echo_in, fault_clr,
    output burst_en, burst_rstn, ch_sel, detected, tof, tof_ch, tof_valid, burst_fault
  );
endinterface

// File: rtl/us_multich_detect_ctrl.sv
// Ultrasonic burst/listen controller: round-robin channels, windowed hysteretic
// echo detection, time-of-flight reporting and burst-generator timeout flag.
module us_multich_detect_ctrl #(
  parameter int NCH            = 2,
  parameter int CNT_W          = 20,
  parameter int PERIOD_CYC     = 43000,
  parameter int BLANK_CYC      = 17000,
  parameter int BURST_TIMEOUT  = 4095,
  parameter int BURSTS_PER_WIN = 10,
  parameter int THRESH_ON      = 3,
  parameter int THRESH_OFF     = 1
) (
  input logic                     gclk,
  input logic                     rstn,
  us_multich_detect_ctrl_if.slave bus
);
  localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [2:0] {IDLE, BURST, BLANK, LISTEN, EVAL} state_t;

  state_t           state;
  logic [NCH-1:0]   echo_s1, echo_s2, echo_s2_d;
  logic [CNT_W-1:0] timer, tof_reg, tof_q;
  logic             hit;
  logic [5:0]       hit_cnt, burst_idx, hit_final;
  logic [CH_W-1:0]  ch_sel_q, tof_ch_q;
  logic [NCH-1:0]   det_q;
  logic             burst_en_q, burst_rstn_q, tof_valid_q, fault_q;
  logic             echo_edge;

  always_ff @(posedge gclk or negedge rstn) begin
    if (!rstn) begin
      echo_s1   <= '0;
      echo_s2   <= '0;
      echo_s2_d <= '0;
    end else begin
      echo_s1   <= bus.echo_in;
      echo_s2   <= echo_s1;
      echo_s2_d <= echo_s2;
    end
  end

  assign echo_edge = echo_s2[ch_sel_q] & ~echo_s2_d[ch_sel_q];
  assign hit_final = hit_cnt + 6'(hit);

  always_ff @(posedge gclk or negedge rstn) begin
    if (!rstn) begin
      state        <= IDLE;
      timer        <= '0;
      tof_reg      <= '0;
      tof_q        <= '0;
      hit          <= 1'b0;
      hit_cnt      <= '0;
      burst_idx    <= '0;
      ch_sel_q     <= '0;
      tof_ch_q     <= '0;
      det_q        <= '0;
      burst_en_q   <= 1'b0;
      burst_rstn_q <= 1'b1;
      tof_valid_q  <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      tof_valid_q  <= 1'b0;
      burst_rstn_q <= 1'b1;
      if (bus.fault_clr) fault_q <= 1'b0;

      // Losing tuss_ready outranks every state action, including the EVAL
      // decision, so EVAL itself only ever continues to BURST.
      if (state != IDLE && !bus.tuss_ready) begin
        state      <= IDLE;
        burst_en_q <= 1'b0;
        timer      <= '0;
        hit        <= 1'b0;
        hit_cnt    <= '0;
        burst_idx  <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.tuss_ready) begin
              state      <= BURST;
              burst_en_q <= 1'b1;
              timer      <= '0;
            end
          end
          BURST: begin
            if (bus.burst_finish) begin
              burst_en_q   <= 1'b0;
              burst_rstn_q <= 1'b0;
              timer        <= '0;
              state        <= BLANK;
            end else if (timer == CNT_W'(BURST_TIMEOUT)) begin
              fault_q    <= 1'b1;
              burst_en_q <= 1'b0;
              hit        <= 1'b0;
              state      <= EVAL;
            end else begin
              timer <= timer + 1'b1;
            end
          end
          BLANK: begin
            timer <= timer + 1'b1;
            if (timer == CNT_W'(BLANK_CYC - 1)) state <= LISTEN;
          end
          LISTEN: begin
            timer <= timer + 1'b1;
            if (echo_edge && !hit) begin
              hit     <= 1'b1;
              tof_reg <= timer;
            end
            if (timer == CNT_W'(PERIOD_CYC - 1)) state <= EVAL;
          end
          EVAL: begin
            if (hit) begin
              tof_valid_q <= 1'b1;
              tof_q       <= tof_reg;
              tof_ch_q    <= ch_sel_q;
            end
            hit <= 1'b0;
            if (burst_idx == 6'(BURSTS_PER_WIN - 1)) begin
              if (hit_final >= 6'(THRESH_ON))       det_q[ch_sel_q] <= 1'b1;
              else if (hit_final <= 6'(THRESH_OFF)) det_q[ch_sel_q] <= 1'b0;
              hit_cnt   <= '0;
              burst_idx <= '0;
              ch_sel_q  <= (ch_sel_q == CH_W'(NCH - 1)) ? '0 : ch_sel_q + 1'b1;
            end else begin
              hit_cnt   <= hit_final;
              burst_idx <= burst_idx + 1'b1;
            end
            state      <= BURST;
            burst_en_q <= 1'b1;
            timer      <= '0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.burst_en    = burst_en_q;
  assign bus.burst_rstn  = burst_rstn_q;
  assign bus.ch_sel      = ch_sel_q;
  assign bus.detected    = det_q;
  assign bus.tof         = tof_q;
  assign bus.tof_ch      = tof_ch_q;
  assign bus.tof_valid   = tof_valid_q;
  assign bus.burst_fault = fault_q;
endmodule

// File: tb/tb_us_multich_detect_ctrl.sv
// Directed per-burst vector table plus hand sequences for abort, fault and reset.
module tb_us_multich_detect_ctrl;
  localparam int NCH = 2;
  localparam int CW  = 20;
  localparam int G   = 10;   // generator finish delay after burst_en
  localparam int B   = 40;   // BLANK_CYC
  localparam int P   = 120;  // PERIOD_CYC
  localparam int TO  = 30;   // BURST_TIMEOUT
  localparam int NOISE_D = 45;

  typedef struct {
    int         ch;
    int         d1;
    int         d2;
    bit         wh;
    bit         stray;
    bit         hit;
    int         tof;
    logic [1:0] det;
    int         exch;
  } vec_t;

  logic gclk = 1'b0;
  logic rstn;
  int   checks = 0;
  int   failures = 0;

  us_multich_detect_ctrl_if #(.NCH(NCH), .CNT_W(CW)) bus ();

  us_multich_detect_ctrl #(
    .NCH(NCH), .CNT_W(CW), .PERIOD_CYC(P), .BLANK_CYC(B), .BURST_TIMEOUT(TO),
    .BURSTS_PER_WIN(4), .THRESH_ON(3), .THRESH_OFF(1)
  ) dut (
    .gclk(gclk),
    .rstn(rstn),
    .bus(bus)
  );

  always #5 gclk = ~gclk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, act=running req=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: act=%0h req=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(int ch, int d1, int d2, bit wh, bit stray, bit hit, int tof,
                              logic [1:0] det, int exch);
    vec_t v;
    v.ch = ch; v.d1 = d1; v.d2 = d2; v.wh = wh; v.stray = stray;
    v.hit = hit; v.tof = tof; v.det = det; v.exch = exch;
    return v;
  endfunction

  function automatic bit pulse(int k, int d);
    return (d != 0) && (k >= d) && (k <= d + 2);
  endfunction

  task automatic check_reset_vals(input string tag);
    chk({tag, "_burst_en"},   32'(bus.burst_en), 0);
    chk({tag, "_burst_rstn"}, 32'(bus.burst_rstn), 1);
    chk({tag, "_ch_sel"},     32'(bus.ch_sel), 0);
    chk({tag, "_detected"},   32'(bus.detected), 0);
    chk({tag, "_tof"},        32'(bus.tof), 0);
    chk({tag, "_tof_ch"},     32'(bus.tof_ch), 0);
    chk({tag, "_tof_valid"},  32'(bus.tof_valid), 0);
    chk({tag, "_fault"},      32'(bus.burst_fault), 0);
  endtask

  task automatic wait_burst_en(input string tag);
    int n = 0;
    while (!bus.burst_en && n < 100) begin
      @(posedge gclk); #1;
      n++;
    end
    chk({tag, "_burst_en_rise"}, 32'(bus.burst_en), 1);
  endtask

  task automatic give_finish(input string tag);
    for (int i = 1; i < G; i++) begin
      @(posedge gclk); #1;
      if (i == 1) chk({tag, "_tof_valid_one_cycle"}, 32'(bus.tof_valid), 0);
    end
    chk({tag, "_burst_en_held"}, 32'(bus.burst_en), 1);
    bus.burst_finish = 1'b1;
    @(posedge gclk); #1;
    bus.burst_finish = 1'b0;
    chk({tag, "_burst_rstn_low"}, 32'(bus.burst_rstn), 0);
    chk({tag, "_burst_en_drop"},  32'(bus.burst_en), 0);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    string tag;
    logic [1:0] e;
    tag = $sformatf("v%0d", idx);
    wait_burst_en(tag);
    if (v.wh) begin
      for (int k = 1; k <= TO + 1; k++) begin
        @(posedge gclk); #1;
        if (k == 1)  chk({tag, "_tof_valid_one_cycle"}, 32'(bus.tof_valid), 0);
        if (k == TO) chk({tag, "_burst_en_before_to"}, 32'(bus.burst_en), 1);
      end
      chk({tag, "_burst_en_timeout"}, 32'(bus.burst_en), 0);
      chk({tag, "_fault_set"},        32'(bus.burst_fault), 1);
      chk({tag, "_rstn_no_pulse"},    32'(bus.burst_rstn), 1);
      @(posedge gclk); #1;
    end else begin
      give_finish(tag);
      for (int k = 0; k <= P; k++) begin
        if (k >= 1) chk({tag, "_burst_rstn_high"}, 32'(bus.burst_rstn), 1);
        chk({tag, "_no_early_tof_valid"}, 32'(bus.tof_valid), 0);
        chk({tag, "_burst_en_listen"}, 32'(bus.burst_en), 0);
        e = '0;
        e[v.ch]     = pulse(k, v.d1) || pulse(k, v.d2);
        e[1 - v.ch] = pulse(k, NOISE_D);
        bus.echo_in      = e;
        bus.burst_finish = v.stray && (k == 60);
        @(posedge gclk); #1;
      end
    end
    bus.echo_in      = '0;
    bus.burst_finish = 1'b0;
    chk({tag, "_tof_valid"}, 32'(bus.tof_valid), 32'(v.hit));
    if (v.hit) begin
      chk({tag, "_tof"},    32'(bus.tof), v.tof);
      chk({tag, "_tof_ch"}, 32'(bus.tof_ch), v.ch);
    end
    chk({tag, "_detected"}, 32'(bus.detected), 32'(v.det));
    chk({tag, "_ch_sel"},   32'(bus.ch_sel), v.exch);
    chk({tag, "_next_burst"}, 32'(bus.burst_en), 1);
  endtask

  vec_t tbl[28];
  vec_t pre[2];
  vec_t post[4];

  initial begin
    // window A, ch0: four hits incl. later-edge, blank-masked edge and both range limits
    tbl[0]  = mk(0,  50, 80, 0, 0, 1,  52, 2'b00, 0);
    tbl[1]  = mk(0,  20, 70, 0, 0, 1,  72, 2'b00, 0);
    tbl[2]  = mk(0,  38,  0, 0, 0, 1,  40, 2'b00, 0);
    tbl[3]  = mk(0, 117,  0, 0, 0, 1, 119, 2'b01, 1);
    // window B, ch1: just-too-early, just-too-late, timeout, one hit
    tbl[4]  = mk(1,  37,  0, 0, 0, 0,   0, 2'b01, 1);
    tbl[5]  = mk(1, 118,  0, 0, 0, 0,   0, 2'b01, 1);
    tbl[6]  = mk(1,   0,  0, 1, 0, 0,   0, 2'b01, 1);
    tbl[7]  = mk(1,  50,  0, 0, 0, 1,  52, 2'b01, 0);
    // window C, ch0: 2 hits hold; stray finish in LISTEN
    tbl[8]  = mk(0,  50,  0, 0, 0, 1,  52, 2'b01, 0);
    tbl[9]  = mk(0,  60,  0, 0, 0, 1,  62, 2'b01, 0);
    tbl[10] = mk(0,   0,  0, 0, 0, 0,   0, 2'b01, 0);
    tbl[11] = mk(0,   0,  0, 0, 1, 0,   0, 2'b01, 1);
    // window D, ch1: 3 hits set
    tbl[12] = mk(1,  50,  0, 0, 0, 1,  52, 2'b01, 1);
    tbl[13] = mk(1,  50,  0, 0, 0, 1,  52, 2'b01, 1);
    tbl[14] = mk(1,  50,  0, 0, 0, 1,  52, 2'b01, 1);
    tbl[15] = mk(1,   0,  0, 0, 0, 0,   0, 2'b11, 0);
    // window E, ch0: 1 hit clears
    tbl[16] = mk(0,  50,  0, 0, 0, 1,  52, 2'b11, 0);
    tbl[17] = mk(0,   0,  0, 0, 0, 0,   0, 2'b11, 0);
    tbl[18] = mk(0,   0,  0, 0, 0, 0,   0, 2'b11, 0);
    tbl[19] = mk(0,   0,  0, 0, 0, 0,   0, 2'b10, 1);
    // window F, ch1: 2 hits hold
    tbl[20] = mk(1,  50,  0, 0, 0, 1,  52, 2'b10, 1);
    tbl[21] = mk(1,  50,  0, 0, 0, 1,  52, 2'b10, 1);
    tbl[22] = mk(1,   0,  0, 0, 0, 0,   0, 2'b10, 1);
    tbl[23] = mk(1,   0,  0, 0, 0, 0,   0, 2'b10, 0);
    // window G, ch0: 3 hits set again
    tbl[24] = mk(0,  50,  0, 0, 0, 1,  52, 2'b10, 0);
    tbl[25] = mk(0,  50,  0, 0, 0, 1,  52, 2'b10, 0);
    tbl[26] = mk(0,  50,  0, 0, 0, 1,  52, 2'b10, 0);
    tbl[27] = mk(0,   0,  0, 0, 0, 0,   0, 2'b11, 1);
    // ch1 partial window (2 hits) then aborted; the restarted window has 0 hits
    pre[0]  = mk(1,  50,  0, 0, 0, 1,  52, 2'b11, 1);
    pre[1]  = mk(1,  50,  0, 0, 0, 1,  52, 2'b11, 1);
    post[0] = mk(1,   0,  0, 0, 0, 0,   0, 2'b11, 1);
    post[1] = mk(1,   0,  0, 0, 0, 0,   0, 2'b11, 1);
    post[2] = mk(1,   0,  0, 0, 0, 0,   0, 2'b11, 1);
    post[3] = mk(1,   0,  0, 0, 0, 0,   0, 2'b01, 0);

    rstn             = 1'b0;
    bus.tuss_ready   = 1'b0;
    bus.burst_finish = 1'b0;
    bus.echo_in      = '0;
    bus.fault_clr    = 1'b0;
    repeat (3) @(posedge gclk);
    #1;
    check_reset_vals("por");
    rstn = 1'b1;
    @(posedge gclk); #1;
    chk("idle_burst_en", 32'(bus.burst_en), 0);
    bus.tuss_ready = 1'b1;

    for (int i = 0; i < 28; i++) run_vec(tbl[i], i);

    chk("fault_sticky", 32'(bus.burst_fault), 1);
    bus.fault_clr = 1'b1;
    @(posedge gclk); #1;
    bus.fault_clr = 1'b0;
    chk("fault_cleared", 32'(bus.burst_fault), 0);

    for (int i = 0; i < 2; i++) run_vec(pre[i], 100 + i);

    wait_burst_en("abort");
    give_finish("abort");
    repeat (60) @(posedge gclk);
    #1;
    bus.tuss_ready = 1'b0;
    for (int k = 0; k < 80; k++) begin
      @(posedge gclk); #1;
      chk("abort_burst_en", 32'(bus.burst_en), 0);
      chk("abort_no_tof_valid", 32'(bus.tof_valid), 0);
    end
    chk("abort_ch_sel", 32'(bus.ch_sel), 1);
    chk("abort_detected", 32'(bus.detected), 32'(2'b11));
    bus.tuss_ready = 1'b1;

    for (int i = 0; i < 4; i++) run_vec(post[i], 200 + i);

    // fault_clr coinciding with the timeout edge: the set wins
    wait_burst_en("prio");
    for (int k = 1; k <= TO + 1; k++) begin
      @(posedge gclk); #1;
      if (k == TO) begin
        chk("prio_fault_before", 32'(bus.burst_fault), 0);
        bus.fault_clr = 1'b1;
      end
    end
    bus.fault_clr = 1'b0;
    chk("prio_burst_en_timeout", 32'(bus.burst_en), 0);
    chk("prio_fault_set_wins", 32'(bus.burst_fault), 1);

    @(posedge gclk); #1;
    chk("rst_pre_burst_en", 32'(bus.burst_en), 1);
    #2 rstn = 1'b0;
    #1;
    check_reset_vals("midrst");
    repeat (2) @(posedge gclk);
    #1 rstn = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
